// File: rtl/wdt_pkg.sv
// Shared types and default constants for the watchdog controller.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WARN  = 2'd2,
        BITE  = 2'd3
    } wdt_state_t;

    localparam int unsigned WDT_DEF_TIMEOUT = 32'd1000;
    localparam int unsigned WDT_BITE_LEN    = 16;

endpackage

// File: rtl/wdt_bite_gen.sv
// Pulse stretcher: a start strobe holds busy high for exactly BITE_LEN cycles,
// with done flagging the final busy cycle.
module wdt_bite_gen #(
    parameter int BITE_LEN = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CW = (BITE_LEN > 1) ? $clog2(BITE_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITE_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= LAST;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/watchdog_timer_ctrl.sv
// Watchdog sequencer: kick-reloaded down-counter with optional warning
// interrupt and a fixed-length bite (reset request) on expiry.
module watchdog_timer_ctrl
    import wdt_pkg::*;
#(
    parameter int          CNT_WIDTH   = 32,
    parameter int          BITE_LEN    = WDT_BITE_LEN,
    parameter int unsigned DEF_TIMEOUT = WDT_DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 kick,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_timeout,
    input  logic [CNT_WIDTH-1:0] cfg_warn,
    output logic                 warn_irq,
    output logic                 wdt_bite,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic [1:0]           state_out
);

    localparam logic [CNT_WIDTH-1:0] RST_TIMEOUT = CNT_WIDTH'(DEF_TIMEOUT);

    wdt_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] warn_q, warn_d;
    logic                 warn_irq_q, warn_irq_d;
    logic [CNT_WIDTH-1:0] cfg_timeout_eff;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic                 warn_en;
    logic                 bite_start, bite_busy, bite_done;

    // A zero timeout would expire before it could ever be kicked; clamp to 1.
    assign cfg_timeout_eff = (cfg_timeout == '0) ? CNT_WIDTH'(1) : cfg_timeout;
    assign cnt_dec         = (cnt_q == '0) ? '0 : cnt_q - CNT_WIDTH'(1);
    assign warn_en         = (warn_q != '0) && (warn_q < timeout_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= RST_TIMEOUT;
            timeout_q  <= RST_TIMEOUT;
            warn_q     <= '0;
            warn_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            warn_q     <= warn_d;
            warn_irq_q <= warn_irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        warn_d     = warn_q;
        warn_irq_d = warn_irq_q;
        bite_start = 1'b0;
        case (state_q)
            IDLE: begin
                warn_irq_d = 1'b0;
                if (cfg_valid) begin
                    timeout_d = cfg_timeout_eff;
                    warn_d    = cfg_warn;
                end
                // Counter tracks the (possibly just written) timeout while idle.
                cnt_d = timeout_d;
                if (enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d    = IDLE;
                    cnt_d      = timeout_q;
                    warn_irq_d = 1'b0;
                end else if (kick) begin
                    cnt_d = timeout_q;
                end else if (cnt_q == '0) begin
                    state_d    = BITE;
                    bite_start = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                    if (warn_en && (cnt_dec <= warn_q)) begin
                        state_d    = WARN;
                        warn_irq_d = 1'b1;
                    end
                end
            end
            WARN: begin
                if (!enable) begin
                    state_d    = IDLE;
                    cnt_d      = timeout_q;
                    warn_irq_d = 1'b0;
                end else if (kick) begin
                    state_d    = COUNT;
                    cnt_d      = timeout_q;
                    warn_irq_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d    = BITE;
                    warn_irq_d = 1'b0;
                    bite_start = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            BITE: begin
                if (bite_done) begin
                    state_d = IDLE;
                    cnt_d   = timeout_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    wdt_bite_gen #(
        .BITE_LEN (BITE_LEN)
    ) u_bite_gen (
        .clk   (clk),
        .rstn  (rstn),
        .start (bite_start),
        .busy  (bite_busy),
        .done  (bite_done)
    );

    assign cfg_ready = (state_q == IDLE);
    assign warn_irq  = warn_irq_q;
    assign wdt_bite  = bite_busy;
    assign cnt_out   = cnt_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_watchdog_timer_ctrl.sv
// Directed bench for watchdog_timer_ctrl: stimulus queues expected state
// transitions, a negedge monitor checks each transition the DUT makes.
module tb_watchdog_timer_ctrl;
    import wdt_pkg::*;

    localparam int W  = 32;
    localparam int EW = W + 21;  // {chk_dt, dt[15:0], state[1:0], warn, bite, cnt}

    logic         clk = 1'b0;
    logic         rstn;
    logic         enable, kick, cfg_valid, cfg_ready;
    logic [W-1:0] cfg_timeout, cfg_warn, cnt_out;
    logic         warn_irq, wdt_bite;
    logic [1:0]   state_out;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic         mon_en = 1'b1;
    int           cyc = 0;
    int           last_cyc = 0;
    logic [1:0]   prev_state = 2'd0;

    watchdog_timer_ctrl #(
        .CNT_WIDTH   (W),
        .BITE_LEN    (16),
        .DEF_TIMEOUT (1000)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .kick        (kick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_timeout (cfg_timeout),
        .cfg_warn    (cfg_warn),
        .warn_irq    (warn_irq),
        .wdt_bite    (wdt_bite),
        .cnt_out     (cnt_out),
        .state_out   (state_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk_exp(input logic [1:0] st, input logic w, input logic b,
                                             input logic [W-1:0] c, input logic chk, input int dt);
        logic [15:0] dt16;
        dt16 = dt[15:0];
        return {chk, dt16, st, w, b, c};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cyc, input string name);
        int k;
        k = 0;
        while (state_out !== s && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (state_out !== s) begin
            n_fail++;
            $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, state_out, k, s);
        end
    endtask

    task automatic do_cfg(input logic [W-1:0] t, input logic [W-1:0] w, input logic en);
        cfg_valid   = 1'b1;
        cfg_timeout = t;
        cfg_warn    = w;
        enable      = en;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int dt;
        cyc++;
        if (!rstn) begin
            prev_state = 2'd0;
            last_cyc   = cyc;
        end else if (state_out != prev_state) begin
            dt = cyc - last_cyc;
            if (mon_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_transition: state %0d->%0d cnt %0d", prev_state, state_out, cnt_out);
                end else begin
                    e = exp_q.pop_front();
                    if (state_out !== e[W+3:W+2] || warn_irq !== e[W+1] || wdt_bite !== e[W] ||
                        cnt_out !== e[W-1:0] || (e[W+20] && dt != int'(e[W+19:W+4]))) begin
                        n_fail++;
                        $display("FAIL transition: got st=%0d warn=%0b bite=%0b cnt=%0d dt=%0d expected st=%0d warn=%0b bite=%0b cnt=%0d dt=%0d(chk=%0b)",
                                 state_out, warn_irq, wdt_bite, cnt_out, dt,
                                 e[W+3:W+2], e[W+1], e[W], e[W-1:0], e[W+19:W+4], e[W+20]);
                    end
                end
            end
            prev_state = state_out;
            last_cyc   = cyc;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int min_cnt;
        logic saw_warn, saw_bite;
        int k;

        rstn        = 1'b0;
        enable      = 1'b0;
        kick        = 1'b0;
        cfg_valid   = 1'b0;
        cfg_timeout = '0;
        cfg_warn    = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        check("rst_state", state_out, 0);
        check("rst_cnt", cnt_out, 1000);
        check("rst_warn", warn_irq, 0);
        check("rst_bite", wdt_bite, 0);
        check("rst_cfg_ready", cfg_ready, 1);

        // Default timeout, no kicks: cnt reaches 0 after 1000 edges, bite the edge after.
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 1000, 1'b0, 0));
        exp_q.push_back(mk_exp(2'd3, 1'b0, 1'b1, 0, 1'b1, 1001));
        exp_q.push_back(mk_exp(2'd0, 1'b0, 1'b0, 1000, 1'b1, 16));
        enable = 1'b1;
        wait_state(2'd3, 1100, "s1_bite");
        enable = 1'b0;
        wait_state(2'd0, 30, "s1_idle");

        // Config and enable in the same cycle; warn at 5 of 20.
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 20, 1'b0, 0));
        exp_q.push_back(mk_exp(2'd2, 1'b1, 1'b0, 5, 1'b1, 15));
        exp_q.push_back(mk_exp(2'd3, 1'b0, 1'b1, 0, 1'b1, 6));
        exp_q.push_back(mk_exp(2'd0, 1'b0, 1'b0, 20, 1'b1, 16));
        do_cfg(20, 5, 1'b1);
        wait_state(2'd3, 40, "s2_bite");
        enable = 1'b0;
        wait_state(2'd0, 30, "s2_idle");

        // warn == timeout disables the warning entirely.
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 8, 1'b0, 0));
        exp_q.push_back(mk_exp(2'd3, 1'b0, 1'b1, 0, 1'b1, 9));
        exp_q.push_back(mk_exp(2'd0, 1'b0, 1'b0, 8, 1'b1, 16));
        do_cfg(8, 8, 1'b1);
        wait_state(2'd3, 30, "s2b_bite");
        enable = 1'b0;
        wait_state(2'd0, 30, "s2b_idle");

        // Kick every 10 cycles; a config attempt mid-count must be ignored.
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 20, 1'b0, 0));
        do_cfg(20, 5, 1'b1);
        min_cnt  = 1 << 30;
        saw_warn = 1'b0;
        saw_bite = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) begin
                cfg_valid   = 1'b1;
                cfg_timeout = 99;
                cfg_warn    = 1;
                check("cfg_ready_count", cfg_ready, 0);
            end
            for (int j = 0; j < 9; j++) begin
                @(negedge clk);
                cfg_valid = 1'b0;
                if (int'(cnt_out) < min_cnt) min_cnt = int'(cnt_out);
                saw_warn |= warn_irq;
                saw_bite |= wdt_bite;
            end
            kick = 1'b1;
            @(negedge clk);
            kick = 1'b0;
            if (int'(cnt_out) < min_cnt) min_cnt = int'(cnt_out);
            saw_warn |= warn_irq;
            saw_bite |= wdt_bite;
        end
        check("kick_min_cnt", min_cnt, 11);
        check("kick_no_warn", saw_warn, 0);
        check("kick_no_bite", saw_bite, 0);
        exp_q.push_back(mk_exp(2'd0, 1'b0, 1'b0, 20, 1'b0, 0));
        enable = 1'b0;
        wait_state(2'd0, 5, "s3_idle");

        // Kick in the very cycle the counter shows 0.
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 20, 1'b0, 0));
        do_cfg(20, 0, 1'b1);
        k = 0;
        while (cnt_out !== '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("s4_reach_zero", cnt_out, 0);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        check("s4_kick_cnt", cnt_out, 20);
        check("s4_kick_state", state_out, 1);
        check("s4_kick_nobite", wdt_bite, 0);
        exp_q.push_back(mk_exp(2'd0, 1'b0, 1'b0, 20, 1'b0, 0));
        enable = 1'b0;
        wait_state(2'd0, 5, "s4_idle");

        // Disable while warning, then a zero timeout stored as 1.
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 20, 1'b0, 0));
        exp_q.push_back(mk_exp(2'd2, 1'b1, 1'b0, 5, 1'b1, 15));
        do_cfg(20, 5, 1'b1);
        wait_state(2'd2, 40, "s5_warn");
        exp_q.push_back(mk_exp(2'd0, 1'b0, 1'b0, 20, 1'b1, 1));
        enable = 1'b0;
        @(negedge clk);
        check("s5_warn_cleared", warn_irq, 0);
        check("s5_state_idle", state_out, 0);
        check("s5_cfg_ready", cfg_ready, 1);
        do_cfg(0, 0, 1'b0);
        check("s5_timeout_clamp", cnt_out, 1);
        exp_q.push_back(mk_exp(2'd1, 1'b0, 1'b0, 1, 1'b0, 0));
        exp_q.push_back(mk_exp(2'd3, 1'b0, 1'b1, 0, 1'b1, 2));
        enable = 1'b1;
        wait_state(2'd3, 10, "s5_bite");
        enable = 1'b0;

        // Asynchronous reset during bite cycle 5, away from any clock edge.
        repeat (4) @(negedge clk);
        check("s6_bite_before_rst", wdt_bite, 1);
        mon_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("s6_rst_bite", wdt_bite, 0);
        check("s6_rst_state", state_out, 0);
        check("s6_rst_warn", warn_irq, 0);
        check("s6_rst_cnt", cnt_out, 1000);
        check("s6_rst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
